// File: rtl/gray_img_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : gray_img_loader_if
// Description : Pixel stream, image-memory write port and engine handshake
//               of the grayscale frame loader.
// Revision    : 1.0  initial release
// ============================================================================
interface gray_img_loader_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  logic              en;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wen;
  logic              ready;
  logic              busy;
  logic              frame_err;
  logic              frame_done;

  // Loader side.
  modport slave (
    input  en, s_valid, s_data, s_last, busy,
    output s_ready, mem_addr, mem_data, mem_wen, ready, frame_err, frame_done
  );

  // Source / engine side.
  modport master (
    output en, s_valid, s_data, s_last, busy,
    input  s_ready, mem_addr, mem_data, mem_wen, ready, frame_err, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/gray_img_loader.sv
`default_nettype none
// ============================================================================
// Module      : gray_img_loader
// Description : Streams one grayscale frame into the image memory, then hands
//               it to the median-filter engine and waits for its release.
// Revision    : 1.0  initial release
// ============================================================================
module gray_img_loader #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int NPIX   = 16384
) (
  input  logic               clk,
  input  logic               reset,
  gray_img_loader_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HAND = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(NPIX - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_s_ready;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_mem_wen;
  logic              r_ready;
  logic              r_frame_err;
  logic              r_frame_done;

  logic w_accept;

  // s_ready is only ever high in S_LOAD, so an accept implies S_LOAD.
  assign w_accept = bus.s_valid & r_s_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_s_ready    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_mem_wen    <= 1'b0;
      r_ready      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_mem_wen    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_frame_done <= 1'b0;

      if (w_accept) begin
        r_mem_wen  <= 1'b1;
        r_mem_addr <= r_cnt;
        r_mem_data <= bus.s_data;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.en) begin
            r_state   <= S_LOAD;
            r_cnt     <= '0;
            r_s_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            if (r_cnt == c_last_addr) begin
              // Full frame stored; a missing s_last is flagged but tolerated.
              r_state     <= S_HAND;
              r_s_ready   <= 1'b0;
              r_frame_err <= ~bus.s_last;
            end else if (bus.s_last) begin
              // Short frame: restart the frame at address 0.
              r_frame_err <= 1'b1;
              r_cnt       <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_HAND: begin
          // ready trails the final write by one cycle.
          if (bus.busy) begin
            r_ready <= 1'b0;
            r_state <= S_WAIT;
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (!bus.busy) begin
            r_frame_done <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.s_ready    = r_s_ready;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_data   = r_mem_data;
  assign bus.mem_wen    = r_mem_wen;
  assign bus.ready      = r_ready;
  assign bus.frame_err  = r_frame_err;
  assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_gray_img_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_img_loader
// Description : Directed vector table plus full-frame sequences with a write
//               scoreboard for gray_img_loader.
// Revision    : 1.0  initial release
// ============================================================================
module tb_gray_img_loader;

  localparam int c_npix = 16384;

  logic clk;
  logic reset;

  gray_img_loader_if #(.ADDR_W(14), .DATA_W(8)) bus ();

  gray_img_loader #(.ADDR_W(14), .DATA_W(8), .NPIX(c_npix)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [13:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  bit  sb_en   = 1'b0;
  int  wr_cnt  = 0;
  int  sb_bad  = 0;
  int  err_cnt = 0;

  // Scoreboard: every write must match the next pixel the bench saw accepted.
  always @(negedge clk) begin
    if (sb_en && bus.mem_wen) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        sb_bad++;
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.a !== bus.mem_addr || mon_e.d !== bus.mem_data) sb_bad++;
      end
    end
    if (sb_en && bus.frame_err) err_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends pixels 0..npix-1 (data = index) with s_last on pixel last_at.
  task automatic stream(input int npix, input int last_at, input bit rnd);
    int k   = 0;
    int cyc = 0;
    bit v;
    bit acc;
    while (k < npix && cyc < 4 * npix + 100) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.s_valid = v;
      bus.s_data  = k[7:0];
      bus.s_last  = (k == last_at);
      acc = v && bus.s_ready;
      if (acc) exp_q.push_back('{a: k[13:0], d: k[7:0]});
      step();
      cyc++;
      if (acc) k++;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    chk("stream_accepted", k, npix);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"},    bus.s_ready,    0);
    chk({tag, "_mem_wen"},    bus.mem_wen,    0);
    chk({tag, "_mem_addr"},   bus.mem_addr,   0);
    chk({tag, "_mem_data"},   bus.mem_data,   0);
    chk({tag, "_ready"},      bus.ready,      0);
    chk({tag, "_frame_err"},  bus.frame_err,  0);
    chk({tag, "_frame_done"}, bus.frame_done, 0);
  endtask

  typedef struct {
    bit          en;
    bit          v;
    logic [7:0]  d;
    bit          l;
    bit          b;
    bit          e_srdy;
    bit          e_wen;
    logic [13:0] e_addr;
    logic [7:0]  e_data;
    bit          e_err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    //          en v  d      l  b  srdy wen addr data   err
    vecs[0] = '{1, 0, 8'h00, 0, 0, 1,   0,  0,   8'h00, 0};
    vecs[1] = '{0, 1, 8'hA5, 0, 0, 1,   1,  0,   8'hA5, 0};
    vecs[2] = '{0, 0, 8'hFF, 0, 0, 1,   0,  0,   8'hA5, 0};
    vecs[3] = '{0, 1, 8'h3C, 0, 0, 1,   1,  1,   8'h3C, 0};
    vecs[4] = '{0, 1, 8'h7E, 0, 1, 1,   1,  2,   8'h7E, 0};
    vecs[5] = '{0, 1, 8'h11, 1, 0, 1,   1,  3,   8'h11, 1};
    vecs[6] = '{0, 1, 8'h22, 0, 0, 1,   1,  0,   8'h22, 0};
    vecs[7] = '{1, 0, 8'h99, 0, 0, 1,   0,  0,   8'h22, 0};
    vecs[8] = '{0, 1, 8'h33, 0, 0, 1,   1,  1,   8'h33, 0};

    reset       = 1'b1;
    bus.en      = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.busy    = 1'b0;

    // Reset state, observed before any clock edge.
    #3;
    chk_all_zero("rst");
    step();
    step();
    reset = 1'b0;
    step();
    chk("idle_s_ready", bus.s_ready, 0);

    // Directed vectors: start, gaps, ignored busy/en, short frame restart.
    foreach (vecs[i]) begin
      bus.en      = vecs[i].en;
      bus.s_valid = vecs[i].v;
      bus.s_data  = vecs[i].d;
      bus.s_last  = vecs[i].l;
      bus.busy    = vecs[i].b;
      step();
      chk($sformatf("v%0d_s_ready", i), bus.s_ready,   vecs[i].e_srdy);
      chk($sformatf("v%0d_mem_wen", i), bus.mem_wen,   vecs[i].e_wen);
      chk($sformatf("v%0d_addr", i),    bus.mem_addr,  vecs[i].e_addr);
      chk($sformatf("v%0d_data", i),    bus.mem_data,  vecs[i].e_data);
      chk($sformatf("v%0d_err", i),     bus.frame_err, vecs[i].e_err);
      chk($sformatf("v%0d_ready", i),   bus.ready,     0);
    end
    bus.en = 1'b0; bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.busy = 1'b0;

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_s_ready", bus.s_ready, 0);

    // Full frame, continuous valid, s_last on the final pixel.
    sb_en = 1'b1;
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    chk("f1_s_ready", bus.s_ready, 1);
    stream(c_npix, c_npix - 1, 1'b0);
    chk("f1_last_wen",   bus.mem_wen,  1);
    chk("f1_last_addr",  bus.mem_addr, c_npix - 1);
    chk("f1_ready_pre",  bus.ready,    0);
    chk("f1_s_ready_lo", bus.s_ready,  0);
    step();
    chk("f1_ready_rise", bus.ready,    1);
    chk("f1_wen_lo",     bus.mem_wen,  0);
    chk("f1_wr_cnt",     wr_cnt,       c_npix);
    chk("f1_wr_order",   sb_bad,       0);
    chk("f1_q_empty",    exp_q.size(), 0);
    chk("f1_err_cnt",    err_cnt,      0);

    // Handshake: ready held until busy, then frame_done once busy drops.
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("hand_hold%0d", i), bus.ready, 1);
    end
    bus.busy = 1'b1;
    step();
    chk("hand_ready_drop", bus.ready, 0);
    step();
    step();
    chk("wait_no_done", bus.frame_done, 0);
    bus.busy = 1'b0;
    step();
    chk("wait_done",    bus.frame_done, 1);
    chk("done_s_ready", bus.s_ready,    0);
    step();
    chk("done_pulse",   bus.frame_done, 0);
    chk("idle_stays",   bus.s_ready,    0);

    // Short frame at pixel 99, then a random-valid resend with no s_last.
    wr_cnt = 0; err_cnt = 0;
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    stream(100, 99, 1'b0);
    chk("early_err",  bus.frame_err, 1);
    chk("early_addr", bus.mem_addr,  99);
    step();
    chk("early_err_pulse", bus.frame_err, 0);
    stream(c_npix, -1, 1'b1);
    chk("nolast_err",   bus.frame_err, 1);
    chk("nolast_ready", bus.ready,     0);
    step();
    chk("nolast_ready_rise", bus.ready, 1);
    chk("f2_err_cnt",   err_cnt,      2);
    chk("f2_wr_cnt",    wr_cnt,       c_npix + 100);
    chk("f2_wr_order",  sb_bad,       0);
    chk("f2_q_empty",   exp_q.size(), 0);
    bus.busy = 1'b1;
    step();
    bus.busy = 1'b0;
    step();
    chk("f2_done", bus.frame_done, 1);

    // Asynchronous reset mid-frame, then a fresh frame from address 0.
    wr_cnt = 0;
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    stream(5000, -1, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk_all_zero("arst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    stream(8, -1, 1'b0);
    step();
    chk("f3_wr_cnt",   wr_cnt,       5008);
    chk("f3_wr_order", sb_bad,       0);
    chk("f3_q_empty",  exp_q.size(), 0);
    chk("f3_no_err",   err_cnt,      2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
